// File: rtl/count_checker.sv
// Receive-side monitor for a 4-bit free-running counter: locks onto the sequence, then flags and counts errors.
// Optional first-error capture is built only when COUNT_CHECK_CAPTURE_EN is defined.
module count_checker #(
  parameter int unsigned SYNC_N = 4,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic              A0,
  input  logic              A1,
  input  logic              A2,
  input  logic              A3,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [3:0]        first_exp,
  output logic [3:0]        first_act,
  output logic              cap_vld
);

  localparam int unsigned VAL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [VAL_W-1:0]    cur, prev, exp_val;
  logic [VAL_W-1:0]    good_cnt, good_cnt_nxt, good_inc;
  logic                e_prev;
  logic                good;
  logic                locked_nxt, err_nxt;
  logic                err_hit, wrap_hit;
  logic [ERR_W-1:0]    err_cnt_nxt;
  logic [WRAP_W-1:0]   wrap_cnt_nxt;

  assign cur      = {A3, A2, A1, A0};
  assign exp_val  = e_prev ? VAL_W'(prev + VAL_W'(1)) : prev;
  assign good     = (cur == exp_val);
  assign good_inc = VAL_W'(good_cnt + VAL_W'(1));

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prev     <= '0;
      e_prev   <= 1'b0;
      good_cnt <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= cur;
      e_prev   <= e;
      good_cnt <= good_cnt_nxt;
      locked   <= locked_nxt;
      err      <= err_nxt;
      err_cnt  <= err_cnt_nxt;
      wrap_cnt <= wrap_cnt_nxt;
    end
  end

  // Next-state, lock tracking and counter updates; clr overrides the counters only
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    locked_nxt   = locked;
    err_nxt      = 1'b0;
    err_hit      = 1'b0;
    wrap_hit     = 1'b0;
    err_cnt_nxt  = err_cnt;
    wrap_cnt_nxt = wrap_cnt;

    case (state)
      IDLE: begin
        state_nxt    = ACQ;
        good_cnt_nxt = '0;
        locked_nxt   = 1'b0;
      end
      ACQ: begin
        if (good) begin
          if (good_inc == VAL_W'(SYNC_N)) begin
            state_nxt    = LOCKED;
            locked_nxt   = 1'b1;
            good_cnt_nxt = '0;
          end else begin
            good_cnt_nxt = good_inc;
          end
        end else begin
          good_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (good) begin
          wrap_hit = e_prev && (prev == 4'hF) && (cur == 4'h0);
        end else begin
          err_nxt      = 1'b1;
          err_hit      = 1'b1;
          locked_nxt   = 1'b0;
          good_cnt_nxt = '0;
          state_nxt    = ACQ;
        end
      end
      default: begin
        state_nxt    = IDLE;
        good_cnt_nxt = '0;
        locked_nxt   = 1'b0;
      end
    endcase

    if (err_hit && (err_cnt != '1)) err_cnt_nxt = ERR_W'(err_cnt + ERR_W'(1));
    if (wrap_hit) wrap_cnt_nxt = WRAP_W'(wrap_cnt + WRAP_W'(1));
    if (clr) begin
      err_cnt_nxt  = '0;
      wrap_cnt_nxt = '0;
    end
  end

`ifdef COUNT_CHECK_CAPTURE_EN
  // Hold the first locked error until clr or reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_exp <= '0;
      first_act <= '0;
      cap_vld   <= 1'b0;
    end else if (clr) begin
      first_exp <= '0;
      first_act <= '0;
      cap_vld   <= 1'b0;
    end else if (err_hit && !cap_vld) begin
      first_exp <= exp_val;
      first_act <= cur;
      cap_vld   <= 1'b1;
    end
  end
`else
  assign first_exp = '0;
  assign first_act = '0;
  assign cap_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: lock, hold, error/relock, saturation, clr priority, async reset, capture.
module tb_count_checker;

  localparam int unsigned ERR_W  = 8;
  localparam int unsigned WRAP_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              e;
  logic              A0, A1, A2, A3;
  logic              clr;
  logic              locked;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [3:0]        first_exp;
  logic [3:0]        first_act;
  logic              cap_vld;

  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  c;

  always #5 clk = ~clk;

  count_checker #(.SYNC_N(4), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .e(e),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
    .first_exp(first_exp), .first_act(first_act), .cap_vld(cap_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the rising edge
  task automatic step(input logic [3:0] v, input logic en, input logic cl);
    @(negedge clk);
    {A3, A2, A1, A0} = v;
    e   = en;
    clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    c = c + 4'd1;
    step(c, 1'b1, 1'b0);
  endtask

  task automatic chk_capture(input string tag, input logic [3:0] fe, input logic [3:0] fa);
`ifdef COUNT_CHECK_CAPTURE_EN
    chk({tag, "_first_exp"}, 32'(first_exp), 32'(fe));
    chk({tag, "_first_act"}, 32'(first_act), 32'(fa));
    chk({tag, "_cap_vld"},   32'(cap_vld),   32'd1);
`else
    chk({tag, "_first_exp"}, 32'(first_exp), 32'd0);
    chk({tag, "_first_act"}, 32'(first_act), 32'd0);
    chk({tag, "_cap_vld"},   32'(cap_vld),   32'd0);
    if (fe == fa) $display("note: capture args equal");
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"},    32'(locked),    32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    chk({tag, "_wrap_cnt"},  32'(wrap_cnt),  32'd0);
    chk({tag, "_first_exp"}, 32'(first_exp), 32'd0);
    chk({tag, "_first_act"}, 32'(first_act), 32'd0);
    chk({tag, "_cap_vld"},   32'(cap_vld),   32'd0);
  endtask

  initial begin
    rst = 1'b0; e = 1'b0; clr = 1'b0; {A3, A2, A1, A0} = 4'd0; c = 4'd0;

    // Reset and initial lock: IDLE capture then four good transitions
    #10;
    chk_all_zero("reset");
    {A3, A2, A1, A0} = 4'd0;
    e = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("lock_p1", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) begin
      adv();
      chk("lock_acq", 32'(locked), 32'd0);
    end
    adv();
    chk("lock_p5", 32'(locked), 32'd1);
    chk("lock_err", 32'(err), 32'd0);
    while (c != 4'd15) begin
      adv();
      chk("run_err", 32'(err), 32'd0);
    end
    chk("pre_wrap", 32'(wrap_cnt), 32'd0);
    adv();
    chk("wrap_cnt", 32'(wrap_cnt), 32'd1);
    chk("wrap_locked", 32'(locked), 32'd1);

    // Hold cycles stay locked; then a 7->9 jump is one error
    for (int i = 0; i < 6; i++) adv();
    step(4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(4'd7, 1'b0, 1'b0);
      chk("hold_locked", 32'(locked), 32'd1);
      chk("hold_err", 32'(err), 32'd0);
    end
    step(4'd7, 1'b1, 1'b0);
    step(4'd9, 1'b1, 1'b0);
    c = 4'd9;
    chk("jump_err", 32'(err), 32'd1);
    chk("jump_err_cnt", 32'(err_cnt), 32'd1);
    chk("jump_locked", 32'(locked), 32'd0);
    adv();
    chk("jump_err_pulse", 32'(err), 32'd0);
    adv(); adv();
    chk("relock_pre", 32'(locked), 32'd0);
    adv();
    chk("relock", 32'(locked), 32'd1);

    // Saturation of err_cnt over 300 error/relock rounds
    for (int i = 0; i < 300; i++) begin
      c = c + 4'd2;
      step(c, 1'b1, 1'b0);
      chk("sat_err", 32'(err), 32'd1);
      chk("sat_err_cnt", 32'(err_cnt), (i + 2 > 255) ? 32'd255 : 32'(i + 2));
      repeat (4) adv();
      chk("sat_relock", 32'(locked), 32'd1);
    end
    chk("sat_final", 32'(err_cnt), 32'd255);

    // clr on the same edge as a locked mismatch
    c = c + 4'd2;
    step(c, 1'b1, 1'b1);
    chk("clr_err", 32'(err), 32'd1);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_wrap_cnt", 32'(wrap_cnt), 32'd0);
    chk("clr_cap_vld", 32'(cap_vld), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    // A mismatch during acquisition restarts the run silently
    adv(); adv();
    c = c + 4'd2;
    step(c, 1'b1, 1'b0);
    chk("acq_bad_err", 32'(err), 32'd0);
    chk("acq_bad_err_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      adv();
      chk("acq_restart", 32'(locked), 32'd0);
    end
    adv();
    chk("acq_relock", 32'(locked), 32'd1);

    // First-error capture: expected 4 got 6, then expected 9 got 2
    for (int i = 0; i < 16 && c != 4'd3; i++) adv();
    c = 4'd6;
    step(c, 1'b1, 1'b0);
    chk("cap1_err", 32'(err), 32'd1);
    chk("cap1_err_cnt", 32'(err_cnt), 32'd1);
    chk_capture("cap1", 4'd4, 4'd6);
    repeat (4) adv();
    chk("cap_relock", 32'(locked), 32'd1);
    for (int i = 0; i < 16 && c != 4'd8; i++) adv();
    c = 4'd2;
    step(c, 1'b1, 1'b0);
    chk("cap2_err", 32'(err), 32'd1);
    chk("cap2_err_cnt", 32'(err_cnt), 32'd2);
    chk_capture("cap2", 4'd4, 4'd6);
    repeat (4) adv();

    // Asynchronous reset while locked with err_cnt=3
    c = c + 4'd2;
    step(c, 1'b1, 1'b0);
    repeat (4) adv();
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_err_cnt", 32'(err_cnt), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rst = 1'b1;
    c = 4'd5;
    step(c, 1'b1, 1'b0);
    chk("restart_p1", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) begin
      adv();
      chk("restart_acq", 32'(locked), 32'd0);
    end
    adv();
    chk("restart_lock", 32'(locked), 32'd1);
    chk("restart_err_cnt", 32'(err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
